// File: rtl/weighted_error_combiner_pipe.sv
// rtl/weighted_error_combiner_pipe.sv - pipelined weighted combiner for ADPLL phase-error channels
module weighted_error_combiner_pipe #(
    parameter int NUM_CH       = 4,
    parameter int ERROR_WIDTH  = 8,
    parameter int WEIGHT_WIDTH = 3,
    parameter int SHIFT        = 2,
    parameter int WEIGHT_RESET = 1,
    parameter int SATCNT_WIDTH = 8
) (
    input  logic                             clk_i,
    input  logic                             reset_n_i,
    input  logic                             clear_i,
    input  logic                             valid_i,
    input  logic [NUM_CH*ERROR_WIDTH-1:0]    error_i,
    input  logic [NUM_CH-1:0]                ch_en_i,
    input  logic [NUM_CH*WEIGHT_WIDTH-1:0]   weight_i,
    input  logic                             weight_load_i,
    output logic                             valid_o,
    output logic [ERROR_WIDTH-1:0]           error_comb_o,
    output logic                             sat_o,
    output logic [SATCNT_WIDTH-1:0]          sat_count_o
);

    localparam int PROD_W = ERROR_WIDTH + WEIGHT_WIDTH + 1;
    localparam int SUM_W  = PROD_W + $clog2(NUM_CH) + ((NUM_CH == 1) ? 1 : 0);
    // one spare bit so the rounding bias can never wrap the sum
    localparam int RND_W  = SUM_W + 1;

    localparam logic signed [RND_W-1:0]   MAX_V   = RND_W'((2 ** (ERROR_WIDTH - 1)) - 1);
    localparam logic signed [RND_W-1:0]   MIN_V   = ~MAX_V;
    localparam logic [ERROR_WIDTH-1:0]    OUT_MAX = {1'b0, {(ERROR_WIDTH-1){1'b1}}};
    localparam logic [ERROR_WIDTH-1:0]    OUT_MIN = {1'b1, {(ERROR_WIDTH-1){1'b0}}};

    logic [WEIGHT_WIDTH-1:0]   weight_q [NUM_CH];
    logic signed [PROD_W-1:0]  prod_d   [NUM_CH];
    logic signed [PROD_W-1:0]  prod_q   [NUM_CH];
    logic signed [SUM_W-1:0]   sum_d;
    logic signed [SUM_W-1:0]   sum_q;
    logic signed [RND_W-1:0]   sum_x;
    logic signed [RND_W-1:0]   rnd_d;
    logic signed [RND_W-1:0]   rnd_q;
    logic [ERROR_WIDTH-1:0]    clip_d;
    logic                      sat_d;
    logic                      v1_q;
    logic                      v2_q;
    logic                      v3_q;

    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            prod_d[k] = '0;
            if (ch_en_i[k]) begin
                prod_d[k] = $signed({{(PROD_W-ERROR_WIDTH){error_i[k*ERROR_WIDTH+ERROR_WIDTH-1]}},
                                     error_i[k*ERROR_WIDTH +: ERROR_WIDTH]})
                          * $signed({{(PROD_W-WEIGHT_WIDTH){1'b0}}, weight_q[k]});
            end
        end
    end

    always_comb begin
        sum_d = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            sum_d = sum_d + {{(SUM_W-PROD_W){prod_q[k][PROD_W-1]}}, prod_q[k]};
        end
    end

    assign sum_x = {sum_q[SUM_W-1], sum_q};

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [RND_W-1:0] HALF = RND_W'(2 ** (SHIFT - 1));
            logic signed [RND_W-1:0] biased;
            always_comb begin
                biased = sum_x + HALF;
                rnd_d  = biased >>> SHIFT;
            end
        end else begin : g_noround
            assign rnd_d = sum_x;
        end
    endgenerate

    always_comb begin
        clip_d = rnd_q[ERROR_WIDTH-1:0];
        sat_d  = 1'b0;
        if (rnd_q > MAX_V) begin
            clip_d = OUT_MAX;
            sat_d  = 1'b1;
        end else if (rnd_q < MIN_V) begin
            clip_d = OUT_MIN;
            sat_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int k = 0; k < NUM_CH; k++) begin
                weight_q[k] <= WEIGHT_WIDTH'(WEIGHT_RESET);
                prod_q[k]   <= '0;
            end
            sum_q        <= '0;
            rnd_q        <= '0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            v3_q         <= 1'b0;
            valid_o      <= 1'b0;
            error_comb_o <= '0;
            sat_o        <= 1'b0;
            sat_count_o  <= '0;
        end else begin
            // products latch with the pre-load weights, so a load never affects the same-edge sample
            if (weight_load_i) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    weight_q[k] <= weight_i[k*WEIGHT_WIDTH +: WEIGHT_WIDTH];
                end
            end
            if (valid_i) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    prod_q[k] <= prod_d[k];
                end
            end
            if (v1_q) sum_q <= sum_d;
            if (v2_q) rnd_q <= rnd_d;

            v1_q    <= valid_i & ~clear_i;
            v2_q    <= v1_q & ~clear_i;
            v3_q    <= v2_q & ~clear_i;
            valid_o <= v3_q & ~clear_i;
            sat_o   <= v3_q & ~clear_i & sat_d;
            if (v3_q && !clear_i) error_comb_o <= clip_d;

            if (clear_i) begin
                sat_count_o <= '0;
            end else if (v3_q && sat_d && (sat_count_o != '1)) begin
                sat_count_o <= sat_count_o + SATCNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_weighted_error_combiner_pipe.sv
// tb/tb_weighted_error_combiner_pipe.sv - randomized and directed self-checking bench for weighted_error_combiner_pipe
module tb_weighted_error_combiner_pipe;

    localparam int NCH     = 4;
    localparam int EW      = 8;
    localparam int WW      = 3;
    localparam int SH      = 2;
    localparam int CW      = 8;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam int OMAX    = (1 << (EW - 1)) - 1;
    localparam int OMIN    = -(1 << (EW - 1));

    logic                clk_i = 1'b0;
    logic                reset_n_i;
    logic                clear_i;
    logic                valid_i;
    logic [NCH*EW-1:0]   error_i;
    logic [NCH-1:0]      ch_en_i;
    logic [NCH*WW-1:0]   weight_i;
    logic                weight_load_i;
    logic                valid_o;
    logic [EW-1:0]       error_comb_o;
    logic                sat_o;
    logic [CW-1:0]       sat_count_o;

    weighted_error_combiner_pipe #(
        .NUM_CH(NCH), .ERROR_WIDTH(EW), .WEIGHT_WIDTH(WW),
        .SHIFT(SH), .WEIGHT_RESET(1), .SATCNT_WIDTH(CW)
    ) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .clear_i(clear_i), .valid_i(valid_i),
        .error_i(error_i), .ch_en_i(ch_en_i), .weight_i(weight_i), .weight_load_i(weight_load_i),
        .valid_o(valid_o), .error_comb_o(error_comb_o), .sat_o(sat_o), .sat_count_o(sat_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct { int due; int val; bit sat; } exp_t;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   mw [NCH];
    int   mcnt    = 0;
    int   mlast   = 0;
    int   vcount  = 0;
    exp_t q [$];

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [NCH*EW-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [EW-1:0] ea, eb, ec, ed;
        ea = EW'(a); eb = EW'(b); ec = EW'(c); ed = EW'(d);
        return {ed, ec, eb, ea};
    endfunction

    // reference: weighted integer sum, floor((sum + half) / 2^SH), then clip
    task automatic ref_calc(output int val, output bit sat);
        int sum, r;
        logic [EW-1:0] e;
        sum = 0;
        for (int k = 0; k < NCH; k++) begin
            e = error_i[k*EW +: EW];
            if (ch_en_i[k]) sum += int'($signed(e)) * mw[k];
        end
        r = (SH > 0) ? ((sum + (1 << (SH - 1))) >>> SH) : sum;
        sat = 1'b0;
        val = r;
        if (r > OMAX) begin val = OMAX; sat = 1'b1; end
        if (r < OMIN) begin val = OMIN; sat = 1'b1; end
    endtask

    task automatic model_reset();
        q.delete();
        for (int k = 0; k < NCH; k++) mw[k] = 1;
        mcnt  = 0;
        mlast = 0;
    endtask

    task automatic tick();
        bit exp_v, exp_s, s;
        int v;
        cyc++;
        exp_v = 1'b0;
        exp_s = 1'b0;
        if (clear_i) begin
            q.delete();
            mcnt = 0;
        end else if (q.size() > 0 && q[0].due == cyc) begin
            exp_v = 1'b1;
            exp_s = q[0].sat;
            mlast = q[0].val;
            if (q[0].sat && mcnt < CNT_MAX) mcnt++;
            q.delete(0);
        end
        if (valid_i && !clear_i) begin
            ref_calc(v, s);
            q.push_back('{cyc + 3, v, s});
        end
        if (weight_load_i) begin
            for (int k = 0; k < NCH; k++) mw[k] = int'(weight_i[k*WW +: WW]);
        end
        @(posedge clk_i);
        #1;
        if (valid_o) vcount++;
        check_eq("valid_o", int'(valid_o), int'(exp_v));
        check_eq("sat_o", int'(sat_o), int'(exp_s));
        check_eq("error_comb_o", int'($signed(error_comb_o)), mlast);
        check_eq("sat_count_o", int'(sat_count_o), mcnt);
    endtask

    task automatic send(input logic [NCH*EW-1:0] e, input logic [NCH-1:0] en);
        valid_i = 1'b1;
        error_i = e;
        ch_en_i = en;
        tick();
        valid_i = 1'b0;
    endtask

    task automatic load_w(input int w);
        for (int k = 0; k < NCH; k++) weight_i[k*WW +: WW] = WW'(w);
        weight_load_i = 1'b1;
        tick();
        weight_load_i = 1'b0;
    endtask

    task automatic do_reset();
        reset_n_i = 1'b0;
        valid_i   = 1'b0;
        clear_i   = 1'b0;
        weight_load_i = 1'b0;
        #1;
        model_reset();
        check_eq("rst_valid_o", int'(valid_o), 0);
        check_eq("rst_sat_o", int'(sat_o), 0);
        check_eq("rst_error_comb_o", int'($signed(error_comb_o)), 0);
        check_eq("rst_sat_count_o", int'(sat_count_o), 0);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        reset_n_i = 1'b1;
    endtask

    initial begin
        reset_n_i = 1'b0;
        clear_i = 1'b0;
        valid_i = 1'b0;
        error_i = '0;
        ch_en_i = '1;
        weight_i = '0;
        weight_load_i = 1'b0;
        model_reset();
        @(posedge clk_i);
        #1;
        do_reset();

        // T1
        send(pack4(4, 8, -4, 12), 4'b1111);
        repeat (3) tick();
        check_eq("t1_result", int'($signed(error_comb_o)), 5);

        // T2: load and sample on the same edge use old weights
        for (int k = 0; k < NCH; k++) weight_i[k*WW +: WW] = 3'd7;
        weight_load_i = 1'b1;
        valid_i = 1'b1;
        error_i = pack4(127, 127, 127, 127);
        tick();
        weight_load_i = 1'b0;
        tick();
        valid_i = 1'b0;
        repeat (2) tick();
        check_eq("t2_old_w", int'($signed(error_comb_o)), 127);
        check_eq("t2_old_sat", int'(sat_o), 0);
        tick();
        check_eq("t2_new_sat", int'(sat_o), 1);
        check_eq("t2_count", int'(sat_count_o), 1);

        // T3: rounding and negative clip
        load_w(1);
        send(pack4(1, 1, 0, 0), 4'b1111);
        repeat (3) tick();
        check_eq("t3_round_up", int'($signed(error_comb_o)), 1);
        send(pack4(-1, -1, 0, 0), 4'b1111);
        repeat (3) tick();
        check_eq("t3_round_zero", int'($signed(error_comb_o)), 0);
        send(pack4(-1, -1, -1, 0), 4'b1111);
        repeat (3) tick();
        check_eq("t3_round_neg", int'($signed(error_comb_o)), -1);
        load_w(7);
        send(pack4(-128, -128, -128, -128), 4'b1111);
        repeat (3) tick();
        check_eq("t3_neg_clip", int'($signed(error_comb_o)), -128);
        check_eq("t3_neg_sat", int'(sat_o), 1);

        // T4: channel enable and streaming
        load_w(1);
        send(pack4(100, 50, 50, 50), 4'b0001);
        repeat (3) tick();
        check_eq("t4_ch_en", int'($signed(error_comb_o)), 25);
        vcount = 0;
        valid_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            error_i = NCH*EW'($urandom());
            ch_en_i = NCH'($urandom());
            tick();
        end
        valid_i = 1'b0;
        repeat (4) tick();
        check_eq("t4_stream_pulses", vcount, 8);

        // T5: clear with two samples in flight plus a simultaneous third
        load_w(3);
        ch_en_i = '1;
        send(pack4(127, 127, 127, 127), 4'b1111);
        send(pack4(-128, 5, 6, 7), 4'b1111);
        clear_i = 1'b1;
        send(pack4(10, 20, 30, 40), 4'b1111);
        clear_i = 1'b0;
        vcount = 0;
        repeat (5) tick();
        check_eq("t5_no_valid", vcount, 0);
        check_eq("t5_count_zero", int'(sat_count_o), 0);
        send(pack4(10, 20, 30, 40), 4'b1111);
        repeat (3) tick();
        check_eq("t5_weights_kept", int'($signed(error_comb_o)), 75);

        // T6: reset mid-stream
        load_w(5);
        valid_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            error_i = NCH*EW'($urandom());
            tick();
        end
        do_reset();
        send(pack4(4, 4, 4, 4), 4'b1111);
        repeat (3) tick();
        check_eq("t6_after_reset", int'($signed(error_comb_o)), 4);

        // counter saturation
        load_w(7);
        valid_i = 1'b1;
        error_i = pack4(127, 127, 127, 127);
        repeat (300) tick();
        valid_i = 1'b0;
        repeat (4) tick();
        check_eq("cnt_sticky", int'(sat_count_o), CNT_MAX);
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        check_eq("cnt_cleared", int'(sat_count_o), 0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            valid_i = 1'($urandom_range(0, 3) != 0);
            error_i = NCH*EW'($urandom());
            ch_en_i = NCH'($urandom());
            clear_i = 1'($urandom_range(0, 39) == 0);
            weight_load_i = 1'($urandom_range(0, 14) == 0);
            weight_i = NCH*WW'($urandom());
            tick();
        end
        valid_i = 1'b0;
        clear_i = 1'b0;
        weight_load_i = 1'b0;
        repeat (4) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
